// File: rtl/mult_pkg.sv
// Shared types and constants for the round-robin shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default operand width / requester count,
//           id_w() helper giving max(1, clog2(n)).
package mult_pkg;

  localparam int DEF_BIT_DEPTH = 4;
  localparam int DEF_NUM_REQ   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Shared shift-add datapath: accumulator {hi, lo}, one conditional add per step.
// Latency: one step per asserted 'step' cycle; BIT_DEPTH steps complete a product.
// Backpressure: none; the controller sequences load/step.
// Ports: clk, reset (sync, active-low), load (init lo=mplier, hi=0), step (one
//        shift-add), mcand/mplier operands, acc_step = accumulator value after
//        the step taken this cycle (combinational, lets the caller register the
//        final product on the last step). BIT_DEPTH must be >= 2.
module shift_add_core #(
  parameter int BIT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     step,
  input  logic [BIT_DEPTH-1:0]     mcand,
  input  logic [BIT_DEPTH-1:0]     mplier,
  output logic [2*BIT_DEPTH-1:0]   acc_step
);

  logic [2*BIT_DEPTH-1:0] acc_q, acc_d;
  logic [BIT_DEPTH-1:0]   addend;
  logic [BIT_DEPTH:0]     sum;

  always_comb begin
    // The low half holds the not-yet-consumed multiplier bits; its LSB
    // decides whether the multiplicand is added into the upper half.
    addend   = acc_q[0] ? mcand : '0;
    // Extra bit keeps the carry, which becomes the new product MSB after
    // the right shift.
    sum      = {1'b0, acc_q[2*BIT_DEPTH-1:BIT_DEPTH]} + {1'b0, addend};
    acc_step = {sum, acc_q[BIT_DEPTH-1:1]};

    acc_d = acc_q;
    if (load) begin
      acc_d = {{BIT_DEPTH{1'b0}}, mplier};
    end else if (step) begin
      acc_d = acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared shift-add multiplier.
// Latency: accept at T -> rsp_valid at T+2+BIT_DEPTH (T+1 for zero operands when
//          MULT_ZERO_BYPASS_EN is defined); IDLE again the cycle after handshake.
// Backpressure: one op in flight; req_ready only in IDLE; DONE holds until rsp_ready.
// Ports: clk, reset (sync, active-low), req_valid/req_ready per requester,
//        req_a/req_b packed operands (requester i at [i*BIT_DEPTH +: BIT_DEPTH]),
//        rsp_valid/rsp_ready, rsp_id, rsp_product (zero when not valid), busy.
// Build option: MULT_ZERO_BYPASS_EN skips LOAD/RUN when either operand is zero.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int  BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int  NUM_REQ   = DEF_NUM_REQ,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BIT_DEPTH-1:0]  req_a,
  input  logic [NUM_REQ*BIT_DEPTH-1:0]  req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*BIT_DEPTH-1:0]        rsp_product,
  output logic                          busy
);

  localparam int CNT_W = id_w(BIT_DEPTH);
  localparam int PW    = 2 * BIT_DEPTH;

  mult_state_e           state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_DEPTH-1:0]  a_q, a_d;
  logic [BIT_DEPTH-1:0]  b_q, b_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]         rsp_product_q, rsp_product_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       srch_idx;
  logic [NUM_REQ-1:0]    gnt_vec;
  logic [BIT_DEPTH-1:0]  sel_a, sel_b;
  logic                  accept;
  logic                  zero_bypass;
  logic                  core_load, core_step;
  logic [PW-1:0]         core_acc_step;

  // Round-robin search starting at rr_ptr_q, wrapping at NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    srch_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      srch_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[srch_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = srch_idx;
      end
    end
  end

  // One-hot grant and operand mux for the winning requester.
  always_comb begin
    gnt_vec = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_id == ID_W'(i))) begin
        gnt_vec[i] = 1'b1;
        sel_a      = req_a[i*BIT_DEPTH +: BIT_DEPTH];
        sel_b      = req_b[i*BIT_DEPTH +: BIT_DEPTH];
      end
    end
  end

  // Reset is synchronous, so a grant shown while it is low would be lost.
  assign accept    = (state_q == ST_IDLE) && reset && gnt_found;
  assign req_ready = accept ? gnt_vec : '0;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_bypass = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    core_load     = 1'b0;
    core_step     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d      = sel_a;
          b_d      = sel_b;
          id_d     = gnt_id;
          rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          if (zero_bypass) begin
            // Product is known to be zero; leave the datapath alone.
            state_d       = ST_DONE;
            rsp_valid_d   = 1'b1;
            rsp_product_d = '0;
            rsp_id_d      = gnt_id;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        core_load = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        core_step = 1'b1;
        if (cnt_q == CNT_W'(BIT_DEPTH - 1)) begin
          // Register the post-step accumulator so the response is ready
          // on the first DONE cycle.
          cnt_d         = '0;
          state_d       = ST_DONE;
          rsp_valid_d   = 1'b1;
          rsp_product_d = core_acc_step;
          rsp_id_d      = id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_product_d = '0;
          rsp_id_d      = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  shift_add_core #(
    .BIT_DEPTH (BIT_DEPTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .step     (core_step),
    .mcand    (a_q),
    .mplier   (b_q),
    .acc_step (core_acc_step)
  );

  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter BIT_DEPTH, default 4, operand width in bits; product is 2*BIT_DEPTH bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; ID_W = max(1, clog2(NUM_REQ)).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 req_ready  out  NUM_REQ  per-requester accept, at most one bit set.
REQ-007 req_a  in  NUM_REQ*BIT_DEPTH  packed multiplicands, requester i at bits [i*BIT_DEPTH +: BIT_DEPTH].
REQ-008 req_b  in  NUM_REQ*BIT_DEPTH  packed multipliers, same packing.
REQ-009 rsp_valid  out  1  result valid.
REQ-010 rsp_ready  in  1  result consumer ready.
REQ-011 rsp_id  out  ID_W  index of the requester that owns the result.
REQ-012 rsp_product  out  2*BIT_DEPTH  unsigned product req_a*req_b.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, LOAD, RUN, DONE; one shared shift-add datapath; one operation in flight.
REQ-015 In IDLE, req_ready is the combinational round-robin grant over req_valid; in all other states req_ready is 0.
REQ-016 Round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0; on accept of index g, rr_ptr <= (g+1) mod NUM_REQ.
REQ-017 Accept (req_valid[g] & req_ready[g]) at cycle T: operands and g captured, IDLE -> LOAD.
REQ-018 LOAD (T+1): datapath loaded with multiplier in low half and upper half cleared; -> RUN.
REQ-019 RUN: exactly BIT_DEPTH shift-add steps, cycles T+2..T+1+BIT_DEPTH, step counter 0..BIT_DEPTH-1; -> DONE after last step.
REQ-020 DONE: rsp_valid=1 from T+2+BIT_DEPTH; rsp_product, rsp_id registered and stable while rsp_valid=1.
REQ-021 DONE holds until rsp_valid & rsp_ready; then -> IDLE next cycle with rsp_valid=0; no request accepted in the handshake cycle.
REQ-022 Carry out of each add enters the product MSB; all operands unsigned; no overflow possible (2*BIT_DEPTH result).
REQ-023 Requesters keep req_valid and operands stable until granted; dropping req_valid before grant is legal and removes the request.
REQ-024 rsp_product and rsp_id are 0 whenever rsp_valid=0.

Reset
REQ-025 reset low at a rising edge: state IDLE, rr_ptr 0, step counter 0, datapath cleared, rsp_valid 0, rsp_product 0, rsp_id 0, busy 0.
REQ-026 Reset mid-operation (LOAD/RUN/DONE) aborts the operation; no response is ever produced for it.
REQ-027 req_ready is 0 during any cycle with reset low.

Configuration
REQ-028 Macro MULT_ZERO_BYPASS_EN defined: accept with captured a==0 or b==0 goes IDLE -> DONE directly, rsp_valid at T+1, product 0, datapath untouched.
REQ-029 MULT_ZERO_BYPASS_EN undefined: zero operands take the full LOAD/RUN path, rsp_valid at T+2+BIT_DEPTH.

Structure
REQ-030 Package mult_pkg holds the FSM state enum typedef, default BIT_DEPTH/NUM_REQ constants and the ID_W helper function.
REQ-031 One sub-module shift_add_core: accumulator, adder and shift, controlled by load/step inputs; FSM, arbiter, capture registers stay in mult_arbiter.

Verification
REQ-032 Single request id 2, a=7, b=9, accept at T, rsp_ready=1 -> rsp_valid at T+6, rsp_product=63, rsp_id=2, back to IDLE at T+7.
REQ-033 After reset, all four req_valid held with a=15, b=15 -> grant order 0,1,2,3, each product 225, then wrap to 0.
REQ-034 rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_product, rsp_id stable, req_ready=0 throughout; response retires on 4th cycle.
REQ-035 reset low during RUN of a=5, b=3 -> rsp_valid never asserts for it, rr_ptr=0, next request (id 1, a=3, b=4) returns 12 at T+6.
REQ-036 a=0, b=13: with MULT_ZERO_BYPASS_EN rsp_valid at T+1, product 0; without it rsp_valid at T+6, product 0.
